instr_fetch: RTL and testbench

//  Instruction-supply side of the 9-bit ISA control interface. Holds program memory and the PC.

---
 rtl/instr_fetch_if.sv | 53 +++++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles every non-clock/reset signal of the instruction fetch unit.
//   master : host/loader + decoder side (drives start, loads, LUT writes,
//            branch/how_high; observes instr, pc, instr_valid, done)
//   slave  : the fetch unit itself
// Signals:
//   start        1     pulse, begin execution at PC 0 (ignored while running)
//   load_en      1     program-memory write strobe
//   load_addr    PC_W  program-memory write address
//   load_data    IW    program-memory write data
//   lut_wr_en    1     branch-target LUT write strobe
//   lut_wr_idx   2     LUT entry to write
//   lut_wr_data  PC_W  absolute branch target
//   branch       1     decoder Branch (already qualified by zero)
//   how_high     2     LUT index used for a taken branch
//   instr        IW    current instruction, imem[pc]
//   pc           PC_W  current program counter
//   instr_valid  1     high only while running
//   done         1     high once the program has completed
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int PC_W = 10,
  parameter int IW   = 9
);
  logic            start;
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [IW-1:0]   load_data;
  logic            lut_wr_en;
  logic [1:0]      lut_wr_idx;
  logic [PC_W-1:0] lut_wr_data;
  logic            branch;
  logic [1:0]      how_high;
  logic [IW-1:0]   instr;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic            done;

  modport master (
    output start, load_en, load_addr, load_data,
    output lut_wr_en, lut_wr_idx, lut_wr_data,
    output branch, how_high,
    input  instr, pc, instr_valid, done
  );

  modport slave (
    input  start, load_en, load_addr, load_data,
    input  lut_wr_en, lut_wr_idx, lut_wr_data,
    input  branch, how_high,
    output instr, pc, instr_valid, done
  );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction-supply side of the 9-bit core: program memory, PC and a
// 4-entry absolute branch-target LUT. One instruction per cycle in RUN with
// zero fetch latency; next PC is LUT[how_high] on a taken branch, else PC+1
// (wrapping). Executing END_PC completes the program and moves to DONE.
// Ports:
//   clk    in  clock, all state changes on posedge
//   reset  in  synchronous active-high reset (program memory is kept)
//   bus    instr_fetch_if.slave, see the interface file for signal list
// Optional feature:
//   FETCH_HALT_EN  when defined, instruction word 9'h1FF acts as HALT and
//                  ends the program after it retires (pc holds on it).
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int PC_W   = 10,
  parameter int IW     = 9,
  parameter int END_PC = 1023
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] END_PC_V = PC_W'(END_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_q [4];
  logic [PC_W-1:0] lut_d [4];
  logic [IW-1:0]   imem [2**PC_W];
  logic            not_running;
  logic            is_halt;

  // Host-side writes and restarts are only honoured outside RUN.
  assign not_running = (state_q != RUN);

  assign bus.instr       = imem[pc_q];
  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.done        = done_q;

`ifdef FETCH_HALT_EN
  localparam logic [IW-1:0] HALT_WORD = '1;
  assign is_halt = (bus.instr == HALT_WORD);
`else
  assign is_halt = 1'b0;
`endif

  // LUT write path; a write in the start cycle lands before the first
  // RUN cycle, so the first branch already sees the new target.
  always_comb begin
    lut_d = lut_q;
    if (bus.lut_wr_en && not_running) begin
      lut_d[bus.lut_wr_idx] = bus.lut_wr_data;
    end
  end

  // Sequencing. The termination check (END_PC or HALT) wins over a taken
  // branch, and the terminating instruction leaves pc parked on itself.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d       = RUN;
          pc_d          = '0;
          instr_valid_d = 1'b1;
          done_d        = 1'b0;
        end
      end
      RUN: begin
        if (pc_q == END_PC_V || is_halt) begin
          state_d       = DONE;
          instr_valid_d = 1'b0;
          done_d        = 1'b1;
        end else if (bus.branch) begin
          pc_d = lut_q[bus.how_high];
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        pc_d          = '0;
        instr_valid_d = 1'b0;
        done_d        = 1'b0;
      end
    endcase
  end

  // Control state, PC, registered status outputs and the LUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      lut_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
      lut_q         <= lut_d;
    end
  end

  // Program memory: no reset, no write-through (a read of the address
  // being written returns old data until the next cycle).
  always_ff @(posedge clk) begin
    if (!reset && bus.load_en && not_running) begin
      imem[bus.load_addr] <= bus.load_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed self-checking bench for instr_fetch, built with END_PC = 3.
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int PC_W   = 10;
  localparam int IW     = 9;
  localparam int END_PC = 3;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  instr_fetch_if #(.PC_W(PC_W), .IW(IW)) bus ();

  instr_fetch #(.PC_W(PC_W), .IW(IW), .END_PC(END_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: through the rising edge, back to the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input logic [PC_W-1:0] addr, input logic [IW-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic write_lut(input logic [1:0] idx, input logic [PC_W-1:0] data);
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_idx  = idx;
    bus.lut_wr_data = data;
    tick();
    bus.lut_wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Clocks until done rises or the budget runs out; cycles = edges taken.
  task automatic run_until_done(input int limit, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int c;
    tests_run++; if (bus.pc !== 10'd0) begin tests_failed++; $display("[TB] FAIL rst_pc got %0d want 0", bus.pc); end
    tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_valid got %b want 0", bus.instr_valid); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_done got %b want 0", bus.done); end
    for (int i = 0; i < 4; i++) load_word(PC_W'(i), IW'(9'h010 + i));
    load_word(10'd4, 9'h044);
    pulse_start();
    tests_run++; if (bus.instr_valid !== 1'b1 || bus.pc !== 10'd0) begin tests_failed++; $display("[TB] FAIL run_entry got valid=%b pc=%0d want valid=1 pc=0", bus.instr_valid, bus.pc); end
    // LUT[1] is zero after reset, so a taken branch goes back to 0
    bus.branch = 1'b1; bus.how_high = 2'd1;
    tick();
    bus.branch = 1'b0;
    tests_run++; if (bus.pc !== 10'd0) begin tests_failed++; $display("[TB] FAIL lut_rst_branch got %0d want 0", bus.pc); end
    run_until_done(10, c);
    tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_run_timeout got done=%b want 1", bus.done); end
    write_lut(2'd1, 10'd5);
    pulse_start();
    bus.branch = 1'b1; bus.how_high = 2'd1;
    tick();
    bus.branch = 1'b0;
    tests_run++; if (bus.pc !== 10'd5) begin tests_failed++; $display("[TB] FAIL pc_to_5 got %0d want 5", bus.pc); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (bus.pc !== 10'd0 || bus.instr_valid !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_run_reset got pc=%0d valid=%b done=%b want 0/0/0", bus.pc, bus.instr_valid, bus.done); end
  endtask

  task automatic test_sequential();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus.pc !== PC_W'(i) || bus.instr !== IW'(9'h010 + i) || bus.instr_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL seq_step%0d got pc=%0d instr=%h valid=%b want pc=%0d instr=%h valid=1", i, bus.pc, bus.instr, bus.instr_valid, i, 9'h010 + i);
      end
      tick();
    end
    tests_run++; if (bus.done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 10'd3) begin tests_failed++; $display("[TB] FAIL seq_done got done=%b valid=%b pc=%0d want 1/0/3", bus.done, bus.instr_valid, bus.pc); end
    tick();
    tests_run++; if (bus.done !== 1'b1 || bus.pc !== 10'd3) begin tests_failed++; $display("[TB] FAIL seq_hold got done=%b pc=%0d want 1/3", bus.done, bus.pc); end
  endtask

  task automatic test_load_start();
    int c;
    bus.load_en = 1'b1; bus.load_addr = 10'd0; bus.load_data = 9'h0C3;
    bus.start = 1'b1;
    tick();
    bus.load_en = 1'b0; bus.start = 1'b0;
    tests_run++; if (bus.pc !== 10'd0 || bus.instr_valid !== 1'b1 || bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart got pc=%0d valid=%b done=%b want 0/1/0", bus.pc, bus.instr_valid, bus.done); end
    tests_run++; if (bus.instr !== 9'h0C3) begin tests_failed++; $display("[TB] FAIL load_start_instr got %h want 0c3", bus.instr); end
    run_until_done(10, c);
    tests_run++; if (c !== 4) begin tests_failed++; $display("[TB] FAIL load_start_len got %0d want 4", c); end
  endtask

  task automatic test_branch();
    int c;
    write_lut(2'd2, 10'd40);
    // LUT write in the same cycle as start
    bus.lut_wr_en = 1'b1; bus.lut_wr_idx = 2'd1; bus.lut_wr_data = 10'd7;
    bus.start = 1'b1;
    tick();
    bus.lut_wr_en = 1'b0; bus.start = 1'b0;
    bus.branch = 1'b1; bus.how_high = 2'd1;
    tick();
    tests_run++; if (bus.pc !== 10'd7) begin tests_failed++; $display("[TB] FAIL br_same_cycle_lut got %0d want 7", bus.pc); end
    bus.how_high = 2'd2;
    tick();
    tests_run++; if (bus.pc !== 10'd40) begin tests_failed++; $display("[TB] FAIL br_taken got %0d want 40", bus.pc); end
    bus.branch = 1'b0;
    tick();
    tests_run++; if (bus.pc !== 10'd41) begin tests_failed++; $display("[TB] FAIL br_after got %0d want 41", bus.pc); end
    run_until_done(2000, c);
    tests_run++; if (c !== 987 || bus.pc !== 10'd3) begin tests_failed++; $display("[TB] FAIL br_run_len got cycles=%0d pc=%0d want 987/3", c, bus.pc); end
    pulse_start();
    bus.branch = 1'b1; bus.how_high = 2'd1;
    tick();
    bus.branch = 1'b0;
    tick();
    tests_run++; if (bus.pc !== 10'd8) begin tests_failed++; $display("[TB] FAIL br_not_taken got %0d want 8", bus.pc); end
    run_until_done(2000, c);
    tests_run++; if (c !== 1020 || bus.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL br_run2_len got cycles=%0d done=%b want 1020/1", c, bus.done); end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_pc [5];
    exp_pc = '{10'd1023, 10'd0, 10'd1, 10'd2, 10'd3};
    write_lut(2'd0, 10'd1023);
    pulse_start();
    bus.branch = 1'b1; bus.how_high = 2'd0;
    tick();
    bus.branch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus.pc !== exp_pc[i] || bus.done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wrap_step%0d got pc=%0d done=%b want pc=%0d done=0", i, bus.pc, bus.done, exp_pc[i]);
      end
      tick();
    end
    tests_run++; if (bus.done !== 1'b1 || bus.pc !== 10'd3) begin tests_failed++; $display("[TB] FAIL wrap_done got done=%b pc=%0d want 1/3", bus.done, bus.pc); end
  endtask

  task automatic test_ignored_writes();
    write_lut(2'd3, 10'd4);
    pulse_start();
    bus.load_en = 1'b1; bus.load_addr = 10'd4; bus.load_data = 9'h155;
    bus.lut_wr_en = 1'b1; bus.lut_wr_idx = 2'd3; bus.lut_wr_data = 10'd9;
    bus.start = 1'b1;
    bus.branch = 1'b1; bus.how_high = 2'd3;
    tick();
    bus.load_en = 1'b0; bus.lut_wr_en = 1'b0; bus.start = 1'b0;
    tests_run++; if (bus.pc !== 10'd4) begin tests_failed++; $display("[TB] FAIL ign_start got pc=%0d want 4", bus.pc); end
    tests_run++; if (bus.instr !== 9'h044) begin tests_failed++; $display("[TB] FAIL ign_load got %h want 044", bus.instr); end
    tick();
    tests_run++; if (bus.pc !== 10'd4) begin tests_failed++; $display("[TB] FAIL ign_lut got pc=%0d want 4", bus.pc); end
    bus.branch = 1'b0;
    tick();
    tests_run++; if (bus.pc !== 10'd5) begin tests_failed++; $display("[TB] FAIL ign_seq got pc=%0d want 5", bus.pc); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (bus.pc !== 10'd0 || bus.instr !== 9'h0C3 || bus.instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mem_kept got pc=%0d instr=%h valid=%b want 0/0c3/0", bus.pc, bus.instr, bus.instr_valid); end
  endtask

  task automatic test_halt();
    int c;
    load_word(10'd1, 9'h1FF);
    pulse_start();
    tick();
    tests_run++; if (bus.pc !== 10'd1 || bus.instr !== 9'h1FF || bus.instr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL halt_fetch got pc=%0d instr=%h valid=%b want 1/1ff/1", bus.pc, bus.instr, bus.instr_valid); end
    tick();
`ifdef FETCH_HALT_EN
    tests_run++; if (bus.done !== 1'b1 || bus.pc !== 10'd1 || bus.instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL halt_stop got done=%b pc=%0d valid=%b want 1/1/0", bus.done, bus.pc, bus.instr_valid); end
    tick();
    tests_run++; if (bus.pc !== 10'd1) begin tests_failed++; $display("[TB] FAIL halt_hold got pc=%0d want 1", bus.pc); end
`else
    tests_run++; if (bus.done !== 1'b0 || bus.pc !== 10'd2 || bus.instr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL nohalt_adv got done=%b pc=%0d valid=%b want 0/2/1", bus.done, bus.pc, bus.instr_valid); end
    run_until_done(10, c);
    tests_run++; if (c !== 2 || bus.pc !== 10'd3) begin tests_failed++; $display("[TB] FAIL nohalt_end got cycles=%0d pc=%0d want 2/3", c, bus.pc); end
`endif
    load_word(10'd1, 9'h011);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.lut_wr_en = 1'b0;
    bus.lut_wr_idx  = '0;
    bus.lut_wr_data = '0;
    bus.branch    = 1'b0;
    bus.how_high  = '0;
    tick();
    tick();
    reset = 1'b0;

    test_reset();
    test_sequential();
    test_load_start();
    test_branch();
    test_wrap();
    test_ignored_writes();
    test_halt();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
